alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Multi-cycle 32-bit ALU execute stage. Consumes the 4-bit operation code produced by the ALU
//  control decoder, plus two operands, over a valid/ready handshake. Logic/arith ops finish in
//  one cycle; shifts run iteratively, 1 bit/cycle. Result is held until downstream accepts it.
// PARAMETERS
//  WIDTH   32   operand/result width; power of 2, >= 8
//  SHW     5    shift-amount width = log2(WIDTH); shamt = b[SHW-1:0]
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      operation/operands valid
//  in_ready     out  1      unit can accept; high only in IDLE
//  operation    in   4      0000 AND, 0001 ADD, 0010 SUB, 0011 OR, 0101 SLL, 0110 SRL, 1000 SRA, 1001 SLT
//  a            in   WIDTH  operand A (shift source for SLL/SRL/SRA)
//  b            in   WIDTH  operand B (shamt = b[SHW-1:0] for shifts)
//  out_valid    out  1      result valid
//  out_ready    in   1      downstream accepts result
//  result       out  WIDTH  result
//  zero         out  1      result == 0
//  overflow     out  1      signed overflow (ADD/SUB only, else 0)
//  illegal      out  1      operation code not in table; result forced 0
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, overflow=0, illegal=0, counter=0.
//    rst wins over every other input, including mid-shift and with out_valid pending; in-flight op dropped.
//  - FSM IDLE -> (accept & shift & shamt!=0) SHIFT; IDLE -> (accept, otherwise) DONE;
//    SHIFT -> (counter reaches 0) DONE; DONE -> (out_ready) IDLE.
//  - Accept = in_valid & in_ready, sampled at clock edge. Operands/op latched at accept; later input
//    changes are ignored until back in IDLE. in_ready=0 in SHIFT and DONE (no overlap).
//  - Latency: non-shift op and shift with shamt=0 -> out_valid high the cycle after accept edge.
//    Shift with shamt=k -> out_valid high k+1 cycles after accept edge.
//  - SHIFT: counter loaded with shamt at accept; each cycle shift working reg by 1 and decrement.
//    SLL fills 0, SRL fills 0, SRA replicates MSB. Shamt taken mod WIDTH (upper b bits ignored).
//  - ADD/SUB modulo 2^WIDTH. overflow ADD: a[MSB]==b[MSB] && r[MSB]!=a[MSB];
//    SUB: a[MSB]!=b[MSB] && r[MSB]!=a[MSB]. No carry-out port.
//  - SLT: signed compare; result = {WIDTH-1 zeros, (a<b)}; overflow=0.
//  - Illegal op (e.g. 0100, 0111, 1010-1111): DONE next cycle, result=0, zero=1, illegal=1.
//  - result/zero/overflow/illegal registered; stable while out_valid=1 and out_ready=0.
//  - out_valid & out_ready in DONE: transfer occurs, out_valid drops next cycle, in_ready rises
//    next cycle (one bubble between ops; throughput <= 1 op / 2 cycles).
//  - zero computed on final result, including shift results.
// TESTING
//  1 ADD a=7,b=5, out_ready=1 -> out_valid 1 cycle after accept, result=12, zero=0, overflow=0.
//  2 SUB a=0x80000000,b=1 -> result=0x7FFFFFFF, overflow=1; SUB a=5,b=5 -> result=0, zero=1.
//  3 SRA a=0xF0000000,b=4 -> out_valid exactly 5 cycles after accept, result=0xFF000000;
//    SLL a=1,b=0x25 (shamt 5) -> result=0x20, 6 cycles; SRL a=0x80000000,b=0 -> 0x80000000, 1 cycle.
//  4 SLT a=0xFFFFFFFF,b=1 -> result=1; SLT a=1,b=0xFFFFFFFF -> result=0; AND/OR 0xF0F0,0x0FF0 -> 0x00F0/0xFFF0.
//  5 Backpressure: ADD 3+4 with out_ready=0 for 10 cycles -> result=7 held, in_ready=0, new in_valid
//    ignored; out_ready=1 -> transfer, in_ready=1 next cycle; op=0100 -> illegal=1, result=0.
//  6 Reset mid-op: SLL shamt=20, rst at cycle 8 -> next cycle out_valid=0, in_ready=1, all outputs 0;
//    following ADD 1+1 returns 2 with normal 1-cycle latency.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage.
// Logic and arithmetic ops finish in one cycle. Shifts step one bit per cycle.
// A valid/ready pair sits on each side, and the result is held until the consumer takes it.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;

  localparam logic [1:0] SK_SLL = 2'd0;
  localparam logic [1:0] SK_SRL = 2'd1;
  localparam logic [1:0] SK_SRA = 2'd2;

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] work;
  logic [1:0]       sh_kind;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic [1:0]       new_kind;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sh_next;

  assign accept    = in_valid & in_ready;
  assign shamt     = b[SHW-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = a + b;
  assign diff      = a - b;

  // Decode the incoming op and compute the single-cycle result.
  // For shifts, the value computed here is the shamt=0 result.
  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    new_kind = SK_SLL;
    case (operation)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: begin alu_res = a; is_shift = 1'b1; new_kind = SK_SLL; end
      OP_SRL: begin alu_res = a; is_shift = 1'b1; new_kind = SK_SRL; end
      OP_SRA: begin alu_res = a; is_shift = 1'b1; new_kind = SK_SRA; end
      default: alu_ill = 1'b1;
    endcase
  end

  // Compute the working register after one more 1-bit shift step.
  always_comb begin
    case (sh_kind)
      SK_SRL:  sh_next = {1'b0, work[WIDTH-1:1]};
      SK_SRA:  sh_next = {work[WIDTH-1], work[WIDTH-1:1]};
      default: sh_next = {work[WIDTH-2:0], 1'b0};
    endcase
  end

  // Next-state logic.
  // A shift moves to DONE on the same edge that takes the counter from 1 to 0.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
      SHIFT: if (cnt == CNT_ONE) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: latch operands on accept, step shifts, and register the final outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      work     <= '0;
      sh_kind  <= SK_SLL;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          work     <= a;
          cnt      <= shamt;
          sh_kind  <= new_kind;
          result   <= alu_res;
          zero     <= (alu_res == '0);
          overflow <= alu_ovf;
          illegal  <= alu_ill;
        end
        SHIFT: begin
          work <= sh_next;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            result <= sh_next;
            zero   <= (sh_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit: hand-computed vectors, latency, backpressure, and reset.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal;

  int total = 0;
  int fails = 0;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero),
    .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready high.
  // Latency counts 1 when out_valid is seen in the cycle right after the accept edge.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] er, input logic ez,
                       input logic eo, input logic ei, input int elat);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready_pre"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; operation = op; a = va; b = vb; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; operation = 4'b0011;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " result"}, result, er);
    chk({tag, " zero"}, 32'(zero), 32'(ez));
    chk({tag, " overflow"}, 32'(overflow), 32'(eo));
    chk({tag, " illegal"}, 32'(illegal), 32'(ei));
    @(negedge clk);
    chk({tag, " out_valid_post"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready_post"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int bad;
    rst = 1'b1; in_valid = 1'b0; operation = 4'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst flags", {29'd0, zero, overflow, illegal}, 32'd0);
    rst = 1'b0;

    do_op("add7+5",   4'b0001, 32'd7,         32'd5,         32'd12,        0, 0, 0, 1);
    do_op("sub_ovf",  4'b0010, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 0, 1, 0, 1);
    do_op("sub_zero", 4'b0010, 32'd5,         32'd5,         32'd0,         1, 0, 0, 1);
    do_op("add_ovf",  4'b0001, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 0, 1, 0, 1);
    do_op("sra4",     4'b1000, 32'hF000_0000, 32'd4,         32'hFF00_0000, 0, 0, 0, 5);
    do_op("sll5",     4'b0101, 32'd1,         32'h25,        32'h20,        0, 0, 0, 6);
    do_op("srl0",     4'b0110, 32'h8000_0000, 32'd0,         32'h8000_0000, 0, 0, 0, 1);
    do_op("srl31",    4'b0110, 32'h8000_0000, 32'd31,        32'd1,         0, 0, 0, 32);
    do_op("sll_mod",  4'b0101, 32'd1,         32'd32,        32'd1,         0, 0, 0, 1);
    do_op("sll_zero", 4'b0101, 32'h8000_0000, 32'd1,         32'd0,         1, 0, 0, 2);
    do_op("slt_t",    4'b1001, 32'hFFFF_FFFF, 32'd1,         32'd1,         0, 0, 0, 1);
    do_op("slt_f",    4'b1001, 32'd1,         32'hFFFF_FFFF, 32'd0,         1, 0, 0, 1);
    do_op("and",      4'b0000, 32'hF0F0,      32'h0FF0,      32'h00F0,      0, 0, 0, 1);
    do_op("or",       4'b0011, 32'hF0F0,      32'h0FF0,      32'hFFF0,      0, 0, 0, 1);

    // Backpressure: the result must hold, and a new request must be ignored.
    @(negedge clk);
    in_valid = 1'b1; operation = 4'b0001; a = 32'd3; b = 32'd4; out_ready = 1'b0;
    @(posedge clk);
    #1;
    a = 32'd100; b = 32'd100;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && result === 32'd7 && in_ready === 1'b0)) bad++;
    end
    chk("bp hold", 32'(bad), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp out_valid_post", 32'(out_valid), 32'd0);
    chk("bp in_ready_post", 32'(in_ready), 32'd1);
    chk("bp result_kept", result, 32'd7);

    do_op("ill0100", 4'b0100, 32'd9, 32'd9, 32'd0, 1, 0, 1, 1);
    do_op("ill1111", 4'b1111, 32'd9, 32'd3, 32'd0, 1, 0, 1, 1);

    // Reset in the middle of a 20-step shift.
    @(negedge clk);
    in_valid = 1'b1; operation = 4'b0101; a = 32'd1; b = 32'd20; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid shift busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst result", result, 32'd0);
    chk("midrst flags", {29'd0, zero, overflow, illegal}, 32'd0);
    do_op("add1+1", 4'b0001, 32'd1, 32'd1, 32'd2, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
